pu_riscv_htif_mc: RTL and testbench
===================================

PU_RISCV_HTIF_MC -- requirements
Module: pu_riscv_htif_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of the tohost/fromhost CSR data.
REQ-002 SHALL have parameter HARTS, default 2: number of independent host channels (1..16).
REQ-003 SHALL have parameter POLL_CYCLES, default 16: idle cycles between tohost polls (>=1).
REQ-004 SHALL have parameter WDOG_LIMIT, default 200000: global watchdog expiry count.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port host_csr_req, output, HARTS: per-hart CSR access request.
REQ-008 SHALL have port host_csr_ack, input, HARTS: per-hart CSR access acknowledge.
REQ-009 SHALL have port host_csr_we, output, HARTS: per-hart access type; 1 = write fromhost, 0 = read tohost.
REQ-010 SHALL have port host_csr_tohost, input, HARTS*XLEN: per-hart tohost value, hart h at bits [h*XLEN +: XLEN].
REQ-011 SHALL have port host_csr_fromhost, output, HARTS*XLEN: per-hart fromhost write data, packed as tohost.
REQ-012 SHALL have port done, output, 1: all harts exited or watchdog expired.
REQ-013 SHALL have port pass, output, 1: valid with done; all exit codes zero and no watchdog expiry.
REQ-014 SHALL have port fail_hart, output, $clog2(HARTS) (min 1): lowest-index hart with non-zero exit code.
REQ-015 SHALL have port fail_code, output, XLEN-1: exit code (tohost>>1) of fail_hart.
REQ-016 SHALL have port wdog_expired, output, 1: watchdog reached WDOG_LIMIT.
REQ-017 SHALL have port cmd_count, output, HARTS*16: per-hart count of serviced non-exit commands.

Function
REQ-018 Per-hart FSM states SHALL be WAIT, READ, EVAL, WRITE, EXITED.
REQ-019 WAIT SHALL count POLL_CYCLES cycles, then enter READ.
REQ-020 READ SHALL assert req=1, we=0 and hold them until ack; on the ack cycle, tohost is captured and the FSM enters EVAL.
REQ-021 EVAL (one cycle) SHALL decode the captured value as follows.
  - Zero: go to WAIT.
  - Bit0=1: latch the exit code (bits XLEN-1:1) and go to EXITED.
  - Otherwise: go to WRITE.
REQ-022 WRITE SHALL assert req=1, we=1 and fromhost={captured[XLEN-1:1],1'b1}, all held until ack; on ack, cmd_count increments (saturating at 0xFFFF) and the FSM enters WAIT.
REQ-023 EXITED SHALL be terminal until reset; req=0.
REQ-024 fromhost SHALL be zero whenever not in WRITE.
REQ-025 req SHALL never deassert before ack; ack while req=0 SHALL be ignored.
REQ-026 The watchdog SHALL increment every cycle while done=0; wdog_expired SHALL assert once the count reaches WDOG_LIMIT; the count SHALL saturate.
REQ-027 done SHALL assert on the cycle after the last hart enters EXITED, or on the cycle after the watchdog reaches WDOG_LIMIT; once asserted, done SHALL stay set until reset.
REQ-028 On watchdog expiry, all non-EXITED FSMs SHALL complete any outstanding handshake, then freeze in WAIT.
REQ-029 If a hart exit and watchdog expiry occur in the same cycle, the exit code SHALL still be recorded.
REQ-030 With done=1, pass SHALL be 1 iff no watchdog expiry and all exit codes are zero.
REQ-031 With any code non-zero, fail_hart/fail_code SHALL report the lowest such hart; otherwise both SHALL be 0.
REQ-032 Channels SHALL be fully independent; simultaneous acks on different harts SHALL each be serviced the same cycle.

Reset
REQ-033 On rstn low, all FSMs SHALL go to WAIT with a zeroed poll counter.
REQ-034 On rstn low, req, we, fromhost, done, pass, fail_hart, fail_code, wdog_expired, cmd_count and the watchdog SHALL all go to 0.
REQ-035 Reset mid-handshake SHALL drop req immediately; no captured data survives reset.

Structure
REQ-036 Package pu_riscv_htif_pkg SHALL hold the FSM state enum and the exit-bit/ack-bit position constants.
REQ-037 Sub-module pu_riscv_htif_channel SHALL implement one hart's FSM, poll counter and cmd_count, and SHALL be instantiated HARTS times.
REQ-038 The top level SHALL hold the watchdog and the done/pass/fail aggregation only.

Verification
REQ-039 Scenario – zero ack latency: HARTS=2, both tohost=1, ack same cycle -> done=1, pass=1, fail_code=0.
REQ-040 Scenario – exit-code priority: hart1 tohost=0x7, hart0 tohost=0x5 (both bit0=1) -> done=1, pass=0, fail_hart=0, fail_code=2.
REQ-041 Scenario – command service: hart0 tohost=0x10, ack after 3 cycles -> WRITE asserts we=1 with fromhost=0x11; cmd_count[0]=1; later tohost=1 -> EXITED.
REQ-042 Scenario – watchdog: WDOG_LIMIT=100, tohost held 0 -> wdog_expired=1 and done=1 at cycle 101, pass=0.
REQ-043 Scenario – reset mid-READ: ack withheld, rstn pulsed low -> req=0 asynchronously; after release, FSMs restart in WAIT and the first READ occurs POLL_CYCLES later.
REQ-044 Scenario – handshake hold: ack withheld 50 cycles during WRITE -> req, we and fromhost stay stable for all 50 cycles.

Source files
------------

// File: rtl/pu_riscv_htif_pkg.sv
// Purpose: shared types and constants for the multi-hart HTIF host controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pu_riscv_htif_pkg;

  // Per-hart channel state.
  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    READ   = 3'd1,
    EVAL   = 3'd2,
    WRITE  = 3'd3,
    EXITED = 3'd4
  } htif_state_e;

  // tohost bit that marks an exit request (code lives in the bits above it).
  localparam int EXIT_BIT = 0;
  // fromhost bit set when acknowledging a serviced command.
  localparam int ACK_BIT  = 0;

endpackage

// File: rtl/pu_riscv_htif_channel.sv
// Purpose: one hart's HTIF poll/service FSM with poll counter and command counter.
// Latency: READ starts POLL_CYCLES cycles after entering WAIT; EVAL is one cycle.
// Backpressure: req/we/fromhost held until ack; freeze parks the FSM in WAIT.
// Ports: clk/rstn; freeze (watchdog expired); csr_req/csr_ack/csr_we/csr_tohost/
//        csr_fromhost CSR handshake; exited + exit_code result; cmd_count counter.
module pu_riscv_htif_channel
  import pu_riscv_htif_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int POLL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              freeze,
  output logic              csr_req,
  input  logic              csr_ack,
  output logic              csr_we,
  input  logic [XLEN-1:0]   csr_tohost,
  output logic [XLEN-1:0]   csr_fromhost,
  output logic              exited,
  output logic [XLEN-2:0]   exit_code,
  output logic [15:0]       cmd_count
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  htif_state_e     state_q, state_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [XLEN-1:0] cap_q, cap_d;
  logic [XLEN-2:0] code_q, code_d;
  logic [15:0]     cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT;
      poll_q  <= '0;
      cap_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      cap_q   <= cap_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    cap_d   = cap_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT: begin
        // A frozen channel never polls again.
        if (!freeze) begin
          if (poll_q == PW'(POLL_CYCLES - 1)) begin
            poll_d  = '0;
            state_d = READ;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      READ: begin
        if (csr_ack) begin
          cap_d   = csr_tohost;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (cap_q == '0) begin
          state_d = WAIT;
        end else if (cap_q[EXIT_BIT]) begin
          // Exit is recorded even if the watchdog fires this cycle.
          code_d  = cap_q[XLEN-1:1];
          state_d = EXITED;
        end else if (freeze) begin
          // No handshake is open yet, so a pending command is simply dropped.
          state_d = WAIT;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (csr_ack) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d = WAIT;
        end
      end
      EXITED:  state_d = EXITED;
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    csr_req      = (state_q == READ) || (state_q == WRITE);
    csr_we       = (state_q == WRITE);
    csr_fromhost = '0;
    if (state_q == WRITE) begin
      csr_fromhost          = cap_q;
      csr_fromhost[ACK_BIT] = 1'b1;
    end
  end

  assign exited    = (state_q == EXITED);
  assign exit_code = code_q;
  assign cmd_count = cnt_q;

endmodule

// File: rtl/pu_riscv_htif_mc.sv
// Purpose: multi-hart HTIF host: per-hart channels plus watchdog and pass/fail summary.
// Latency: done one cycle after the last exit or after the watchdog hits its limit.
// Backpressure: each channel holds its CSR request until acked; channels independent.
// Ports: clk/rstn; host_csr_* per-hart packed CSR handshake; done/pass/fail_hart/
//        fail_code/wdog_expired summary; cmd_count per-hart 16-bit counters.
module pu_riscv_htif_mc
  import pu_riscv_htif_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int HARTS       = 2,
  parameter int POLL_CYCLES = 16,
  parameter int WDOG_LIMIT  = 200000
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic [HARTS-1:0]         host_csr_req,
  input  logic [HARTS-1:0]         host_csr_ack,
  output logic [HARTS-1:0]         host_csr_we,
  input  logic [HARTS*XLEN-1:0]    host_csr_tohost,
  output logic [HARTS*XLEN-1:0]    host_csr_fromhost,
  output logic                     done,
  output logic                     pass,
  output logic [((HARTS > 1) ? $clog2(HARTS) : 1)-1:0] fail_hart,
  output logic [XLEN-2:0]          fail_code,
  output logic                     wdog_expired,
  output logic [HARTS*16-1:0]      cmd_count
);

  localparam int HW = (HARTS > 1) ? $clog2(HARTS) : 1;
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  logic [HARTS-1:0] exited;
  logic [XLEN-2:0]  codes [HARTS];

  logic [WW-1:0] wdog_q, wdog_d;
  logic          wexp_q, wexp_d;
  logic          done_q, done_d;
  logic          wdog_hit;
  logic          any_fail;

  for (genvar g = 0; g < HARTS; g++) begin : g_ch
    pu_riscv_htif_channel #(
      .XLEN        (XLEN),
      .POLL_CYCLES (POLL_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rstn         (rstn),
      .freeze       (wexp_q),
      .csr_req      (host_csr_req[g]),
      .csr_ack      (host_csr_ack[g]),
      .csr_we       (host_csr_we[g]),
      .csr_tohost   (host_csr_tohost[g*XLEN +: XLEN]),
      .csr_fromhost (host_csr_fromhost[g*XLEN +: XLEN]),
      .exited       (exited[g]),
      .exit_code    (codes[g]),
      .cmd_count    (cmd_count[g*16 +: 16])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_q <= '0;
      wexp_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      wexp_q <= wexp_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    wdog_hit = (wdog_q == WW'(WDOG_LIMIT));
    wdog_d   = wdog_q;
    if (!done_q && !wdog_hit) wdog_d = wdog_q + 1'b1;
    wexp_d = wexp_q | wdog_hit;
    done_d = done_q | (&exited) | wdog_hit;
  end

  // Descending scan so the lowest failing hart is the one left standing.
  always_comb begin
    fail_hart = '0;
    fail_code = '0;
    any_fail  = 1'b0;
    for (int h = HARTS - 1; h >= 0; h--) begin
      if (codes[h] != '0) begin
        fail_hart = HW'(h);
        fail_code = codes[h];
        any_fail  = 1'b1;
      end
    end
  end

  assign done         = done_q;
  assign wdog_expired = wexp_q;
  assign pass         = done_q & ~wexp_q & ~any_fail;

endmodule

// File: tb/tb_pu_riscv_htif_mc.sv
// Purpose: directed self-checking bench for the multi-hart HTIF host controller.
// Latency: checks exact poll, exit and watchdog cycle counts from reset release.
// Backpressure: exercises zero-latency acks, delayed acks and long ack stalls.
module tb_pu_riscv_htif_mc;

  localparam int XLEN = 32;
  localparam int HARTS = 2;
  localparam int POLL = 4;
  localparam int WDOG = 100;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [HARTS-1:0]      req, ack, we;
  logic [HARTS*XLEN-1:0] tohost, fromhost;
  logic                  done, pass;
  logic                  fail_hart;
  logic [XLEN-2:0]       fail_code;
  logic                  wdog_expired;
  logic [HARTS*16-1:0]   cmd_count;

  int total = 0;
  int bad = 0;

  pu_riscv_htif_mc #(
    .XLEN(XLEN), .HARTS(HARTS), .POLL_CYCLES(POLL), .WDOG_LIMIT(WDOG)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .host_csr_req      (req),
    .host_csr_ack      (ack),
    .host_csr_we       (we),
    .host_csr_tohost   (tohost),
    .host_csr_fromhost (fromhost),
    .done              (done),
    .pass              (pass),
    .fail_hart         (fail_hart),
    .fail_code         (fail_code),
    .wdog_expired      (wdog_expired),
    .cmd_count         (cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] t0;
    logic [31:0] t1;
    logic        exp_pass;
    logic        exp_fh;
    logic [30:0] exp_fc;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reset is released 1ns after a rising edge; the next edge is edge 1.
  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic wait_req(input int h, input logic w, input int limit, input string name);
    int n = 0;
    while (!(req[h] && we[h] == w) && n < limit) begin
      tick();
      n++;
    end
    total++;
    if (!(req[h] && we[h] == w)) begin
      bad++;
      $display("FAIL %s actual=timeout required=req within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s actual=timeout required=done within %0d cycles", name, limit);
    end
  endtask

  initial begin
    logic        stable;
    logic [63:0] fh_snap;

    vecs[0] = '{32'h1,        32'h1,        1'b1, 1'b0, 31'h0};
    vecs[1] = '{32'h5,        32'h7,        1'b0, 1'b0, 31'h2};
    vecs[2] = '{32'h1,        32'h7,        1'b0, 1'b1, 31'h3};
    vecs[3] = '{32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 31'h7FFFFFFF};
    vecs[4] = '{32'h3,        32'h21,       1'b0, 1'b0, 31'h1};
    vecs[5] = '{32'h1,        32'h80000001, 1'b0, 1'b1, 31'h40000000};

    ack = '0;
    tohost = '0;

    // Reset state while rstn is held low.
    rstn = 1'b0;
    tick();
    check("rst_req", 64'(req), 64'h0);
    check("rst_we", 64'(we), 64'h0);
    check("rst_fromhost", fromhost, 64'h0);
    check("rst_done_pass", {62'h0, done, pass}, 64'h0);
    check("rst_fail", {fail_hart, fail_code}, 64'h0);
    check("rst_wdog", 64'(wdog_expired), 64'h0);
    check("rst_cmd", 64'(cmd_count), 64'h0);

    // Exit-only vectors with zero-latency acks: READ at edge 4, EVAL 5,
    // EXITED 6, done at edge 7.
    for (int v = 0; v < 6; v++) begin
      ack = 2'b11;
      tohost = {vecs[v].t1, vecs[v].t0};
      do_reset();
      for (int c = 0; c < 6; c++) tick();
      check($sformatf("v%0d_done_early", v), 64'(done), 64'h0);
      tick();
      check($sformatf("v%0d_done", v), 64'(done), 64'h1);
      check($sformatf("v%0d_pass", v), 64'(pass), 64'(vecs[v].exp_pass));
      check($sformatf("v%0d_fail_hart", v), 64'(fail_hart), 64'(vecs[v].exp_fh));
      check($sformatf("v%0d_fail_code", v), 64'(fail_code), 64'(vecs[v].exp_fc));
      check($sformatf("v%0d_wdog", v), 64'(wdog_expired), 64'h0);
      check($sformatf("v%0d_req_idle", v), 64'(req), 64'h0);
    end

    // Command service with a 3-cycle write ack, then exit.
    ack = 2'b10;
    tohost = {32'h1, 32'h10};
    do_reset();
    wait_req(0, 1'b0, 10, "cmd_read_req");
    check("cmd_read_fromhost", fromhost[31:0], 64'h0);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    wait_req(0, 1'b1, 5, "cmd_write_req");
    check("cmd_write_fromhost", fromhost[31:0], 64'h11);
    for (int c = 0; c < 3; c++) tick();
    check("cmd_write_held", {62'h0, req[0], we[0]}, 64'h3);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    check("cmd_count0", 64'(cmd_count[15:0]), 64'h1);
    check("cmd_req_drop", 64'(req[0]), 64'h0);
    tohost[31:0] = 32'h1;
    ack[0] = 1'b1;
    wait_done(30, "cmd_done");
    check("cmd_pass", 64'(pass), 64'h1);
    check("cmd_counts", 64'(cmd_count), 64'h0000_0001);

    // Write handshake stalled for 50 cycles.
    ack = 2'b10;
    tohost = {32'h1, 32'h2A};
    do_reset();
    wait_req(0, 1'b0, 10, "hold_read_req");
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    wait_req(0, 1'b1, 5, "hold_write_req");
    fh_snap = fromhost;
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (!(req[0] && we[0] && fromhost == fh_snap)) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'h1);
    check("hold_fromhost", fh_snap[31:0], 64'h2B);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    check("hold_cmd", 64'(cmd_count[15:0]), 64'h1);
    tohost[31:0] = 32'h1;
    ack[0] = 1'b1;
    wait_done(30, "hold_done");
    check("hold_pass", 64'(pass), 64'h1);

    // Watchdog: tohost stays zero, so no hart ever exits.
    ack = 2'b11;
    tohost = '0;
    do_reset();
    for (int c = 0; c < WDOG; c++) tick();
    check("wdog_pre", {62'h0, wdog_expired, done}, 64'h0);
    tick();
    check("wdog_hit", {62'h0, wdog_expired, done}, 64'h3);
    check("wdog_pass", 64'(pass), 64'h0);
    for (int c = 0; c < 20; c++) tick();
    check("wdog_frozen_req", 64'(req), 64'h0);
    check("wdog_sticky", {62'h0, wdog_expired, done}, 64'h3);

    // Reset asserted mid-READ with ack withheld.
    ack = 2'b00;
    tohost = {32'h1, 32'h1};
    do_reset();
    wait_req(0, 1'b0, 10, "rst_mid_read_req");
    check("rst_mid_both_req", 64'(req), 64'h3);
    #1;
    rstn = 1'b0;
    #1;
    check("rst_mid_async_drop", 64'(req), 64'h0);
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < POLL - 1; c++) tick();
    check("rst_mid_no_early_read", 64'(req), 64'h0);
    tick();
    check("rst_mid_read_after_poll", {62'h0, req}, 64'h3);
    check("rst_mid_read_type", 64'(we), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
